// File: rtl/sub_pkg.sv
// Shared types and default sizing for the serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

    localparam int WIDTH_DEF = 16;
    localparam int SLICE_DEF = 4;
    localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;
    localparam int CNT_W     = $clog2(NSLICE);

endpackage

// File: rtl/sub_16bit_serial_if.sv
// Request/response channels of the serial subtractor.
// Optional ovf signal exists only when SUB_OVF_EN is defined.
// Handshake: a beat transfers on a clk edge where valid and ready are both high;
// the source holds valid and data stable until that edge, and the sink may
// raise or drop ready freely.
interface sub_16bit_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             Bo;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, Bin, out_ready,
        input  in_ready, out_valid, y, Bo
`ifdef SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, Bin, out_ready,
        output in_ready, out_valid, y, Bo
`ifdef SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/sub_slice.sv
// Combinational SLICE-bit subtract-with-borrow; borrow-out is the MSB of the
// (SLICE+1)-bit difference.
module sub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             bin,
    output logic [SLICE-1:0] d,
    output logic             bout
);
    logic [SLICE:0] diff_ext;

    always_comb begin
        diff_ext = {1'b0, a_s} - {1'b0, b_s} - {{SLICE{1'b0}}, bin};
        d        = diff_ext[SLICE-1:0];
        bout     = diff_ext[SLICE];
    end
endmodule

// File: rtl/sub_16bit_serial.sv
// Serial y = a - b - Bin, one SLICE per cycle, LSB slice first.
// Optional signed-overflow output is enabled with SUB_OVF_EN.
module sub_16bit_serial
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sub_16bit_serial_if.slave    bus,
    output sub_state_t           state_dbg
);
    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam int RW = WIDTH - SLICE;

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [RW-1:0]    res_q, res_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bo_q, bo_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [SLICE-1:0] diff;
    logic             slice_bout;
    logic             last;
`ifdef SUB_OVF_EN
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    // Operands shift right each RUN cycle so the active slice is always at bit 0.
    sub_slice #(.SLICE(SLICE)) u_slice (
        .a_s  (a_sh_q[SLICE-1:0]),
        .b_s  (b_sh_q[SLICE-1:0]),
        .bin  (borrow_q),
        .d    (diff),
        .bout (slice_bout)
    );

    assign last = (cnt_q == CW'(NS - 1));

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_d       = res_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        borrow_d    = borrow_q;
        bo_d        = bo_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SUB_OVF_EN
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d     = bus.a;
                    b_sh_d     = bus.b;
                    borrow_d   = bus.Bin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
`ifdef SUB_OVF_EN
                    a_msb_d    = bus.a[WIDTH-1];
                    b_msb_d    = bus.b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> SLICE;
                b_sh_d   = b_sh_q >> SLICE;
                borrow_d = slice_bout;
                res_d    = {diff, res_q[RW-1:SLICE]};
                cnt_d    = cnt_q + CW'(1);
                // y/Bo are only published on the final slice so they hold the
                // previous result through the whole RUN phase.
                if (last) begin
                    y_d         = {diff, res_q};
                    bo_d        = slice_bout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef SUB_OVF_EN
                    ovf_d       = (a_msb_q != b_msb_q) && (diff[SLICE-1] != a_msb_q);
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_q       <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            bo_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_q       <= res_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            borrow_q    <= borrow_d;
            bo_q        <= bo_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SUB_OVF_EN
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.Bo        = bo_q;
`ifdef SUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_sub_16bit_serial.sv
// Bench for sub_16bit_serial: directed cases, backpressure, reset abort and
// randomized traffic checked by a queue-based scoreboard.
module tb_sub_16bit_serial;
    import sub_pkg::*;

    logic       clk;
    logic       rst_n;
    sub_state_t state_dbg;
    int         compared   = 0;
    int         mismatched = 0;
    logic [17:0] exp_q[$];

    sub_16bit_serial_if #(.WIDTH(16)) bus ();

    sub_16bit_serial #(.WIDTH(16), .SLICE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {ovf, Bo, y} from plain 17-bit arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic bin);
        logic [16:0] r;
        logic        ov;
        r  = {1'b0, a} - {1'b0, b} - {16'b0, bin};
        ov = 1'b0;
`ifdef SUB_OVF_EN
        ov = (a[15] != b[15]) && (r[15] != a[15]);
`endif
        return {ov, r};
    endfunction

    // driver: call at #1 after a posedge; returns #1 after the accepting edge
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin);
        logic acc;
        int   n;
        bus.a = a; bus.b = b; bus.Bin = bin; bus.in_valid = 1'b1;
        n = 0;
        do begin
            acc = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        bus.in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'(n), 32'd0);
        else exp_q.push_back(model(a, b, bin));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result: got y=0x%0h with empty expected queue", bus.y);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                chk("y", 32'(bus.y), 32'(e[15:0]));
                chk("Bo", 32'(bus.Bo), 32'(e[16]));
`ifdef SUB_OVF_EN
                chk("ovf", 32'(bus.ovf), 32'(e[17]));
`endif
            end
        end
    end

    initial begin
        int lat;
        int n;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.Bin = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_Bo", 32'(bus.Bo), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // latency: out_valid appears 4 edges after the accepting edge
        send(16'h0005, 16'h0003, 1'b0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd4);
        chk("y_5_3", 32'(bus.y), 32'h0002);
        chk("Bo_5_3", 32'(bus.Bo), 32'd0);
        drain();

        // wrap-around and overflow corners
        send(16'h0000, 16'h0001, 1'b0);
        send(16'h1234, 16'h1234, 1'b1);
        send(16'h8000, 16'h0001, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b0);
        send(16'h0000, 16'hFFFF, 1'b1);
        drain();

        // backpressure: result held, new request not accepted
        bus.out_ready = 1'b0;
        send(16'h00A5, 16'h005A, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        bus.a = 16'h1111; bus.b = 16'h2222; bus.Bin = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_y", 32'(bus.y), 32'h004B);
            chk("bp_Bo", 32'(bus.Bo), 32'd0);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_state", 32'(state_dbg), 32'(IDLE));
        send(16'h1111, 16'h2222, 1'b0);
        drain();

        // reset in the middle of RUN aborts the operation
        send(16'h4321, 16'h1234, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_y", 32'(bus.y), 32'd0);
        chk("mid_rst_Bo", 32'(bus.Bo), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        send(16'h00FF, 16'h000F, 1'b0);
        drain();

        // random back-to-back traffic
        for (int i = 0; i < 100; i++) begin
            send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
